// File: rtl/sa_skew_feeder.sv
// Operand staging for the 8x8 systolic tile: diagonal skew of A/B lanes plus
// sequencing of one K-step product (clear, feed, zero-drain, done pulse).
module sa_skew_feeder #(
  parameter int DRAIN_CYCLES = 18,
  parameter int LANES        = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [7:0]         k_len_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [8*LANES-1:0] a_vec_i,
  input  logic [8*LANES-1:0] b_vec_i,
  output logic [8*LANES-1:0] row_x_o,
  output logic [8*LANES-1:0] col_x_o,
  output logic               pe_en_o,
  output logic               arr_clr_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int CW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_FIN   = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    k_left_q, k_left_d;
  logic [CW-1:0] drain_q, drain_d;
  logic          accept;
  logic          shift_en;
  logic          clr_en;
  logic          start_ok;

  assign start_ok = start_i && (k_len_i != 8'd0);
  assign accept   = in_valid_i && in_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok) state_d = S_CLEAR;
      S_CLEAR: state_d = S_FEED;
      S_FEED:  if (accept && (k_left_q == 8'd1)) state_d = S_DRAIN;
      S_DRAIN: if (drain_q == CW'(1)) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Every control output decodes state only, so an async reset clears them at once.
  always_comb begin
    in_ready_o = 1'b0;
    pe_en_o    = 1'b0;
    arr_clr_o  = 1'b0;
    busy_o     = 1'b1;
    done_o     = 1'b0;
    shift_en   = 1'b0;
    clr_en     = 1'b0;
    case (state_q)
      S_IDLE:  busy_o = 1'b0;
      S_CLEAR: begin
        arr_clr_o = 1'b1;
        clr_en    = 1'b1;
      end
      S_FEED: begin
        in_ready_o = (k_left_q != 8'd0);
        pe_en_o    = 1'b1;
        shift_en   = 1'b1;
      end
      S_DRAIN: begin
        pe_en_o  = 1'b1;
        shift_en = 1'b1;
      end
      S_FIN:   done_o = 1'b1;
      default: busy_o = 1'b0;
    endcase
  end

  always_comb begin
    k_left_d = k_left_q;
    drain_d  = drain_q;
    if ((state_q == S_IDLE) && start_ok) begin
      k_left_d = k_len_i;
    end
    if (accept) begin
      k_left_d = k_left_q - 8'd1;
    end
    if (accept && (k_left_q == 8'd1)) begin
      drain_d = CW'(DRAIN_CYCLES);
    end else if (state_q == S_DRAIN) begin
      drain_d = drain_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      k_left_q <= 8'd0;
      drain_q  <= '0;
    end else begin
      k_left_q <= k_left_d;
      drain_q  <= drain_d;
    end
  end

  // Lane i is a chain of i+1 registers; non-accept cycles inject zero bubbles.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [7:0] a_sr_q [i+1];
    logic [7:0] b_sr_q [i+1];

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int s = 0; s <= i; s++) begin
          a_sr_q[s] <= 8'h00;
          b_sr_q[s] <= 8'h00;
        end
      end else if (clr_en) begin
        for (int s = 0; s <= i; s++) begin
          a_sr_q[s] <= 8'h00;
          b_sr_q[s] <= 8'h00;
        end
      end else if (shift_en) begin
        a_sr_q[0] <= accept ? a_vec_i[8*i +: 8] : 8'h00;
        b_sr_q[0] <= accept ? b_vec_i[8*i +: 8] : 8'h00;
        for (int s = 1; s <= i; s++) begin
          a_sr_q[s] <= a_sr_q[s-1];
          b_sr_q[s] <= b_sr_q[s-1];
        end
      end
    end

    assign row_x_o[8*i +: 8] = a_sr_q[i];
    assign col_x_o[8*i +: 8] = b_sr_q[i];
  end

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Bench for sa_skew_feeder: a timeline model (start/accept/done times and an
// accept history) checks every output each cycle, plus a vector table and corner sequences.
module tb_sa_skew_feeder;

  localparam int DRAIN = 18;

  logic        clk, rst, start, in_valid;
  logic [7:0]  k_len;
  logic [63:0] a_vec, b_vec;
  logic        in_ready_o, pe_en_o, arr_clr_o, busy_o, done_o;
  logic [63:0] row_x_o, col_x_o;

  sa_skew_feeder dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .k_len_i(k_len),
    .in_valid_i(in_valid), .in_ready_o(in_ready_o),
    .a_vec_i(a_vec), .b_vec_i(b_vec), .row_x_o(row_x_o), .col_x_o(col_x_o),
    .pe_en_o(pe_en_o), .arr_clr_o(arr_clr_o), .busy_o(busy_o), .done_o(done_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int total = 0;
  int bad   = 0;

  // Timeline model: product state expressed as event times, not as FSM states.
  int          cyc = 0;
  bit          active;
  int          t_clr, t_last, k_rem;
  logic [63:0] ha [int];
  logic [63:0] hb [int];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit m_done();
    return active && (t_last >= 0) && (cyc == t_last + DRAIN + 1);
  endfunction
  function automatic bit m_ready();
    return active && (cyc > t_clr) && (k_rem > 0);
  endfunction
  function automatic bit m_clr();
    return active && (cyc == t_clr);
  endfunction
  function automatic bit m_pe();
    return active && (cyc > t_clr) && !m_done();
  endfunction

  // Lane i shows the vector accepted i+1 cycles ago, zero otherwise.
  function automatic logic [63:0] m_lanes(input bit is_a);
    logic [63:0] r;
    logic [63:0] v;
    int c;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      c = cyc - 1 - i;
      if (ha.exists(c)) begin
        v = is_a ? ha[c] : hb[c];
        r[8*i +: 8] = v[8*i +: 8];
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    active = 1'b0;
    t_clr  = -1;
    t_last = -1;
    k_rem  = 0;
    ha.delete();
    hb.delete();
  endtask

  task automatic model_check();
    chk("in_ready", in_ready_o, m_ready());
    chk("arr_clr", arr_clr_o, m_clr());
    chk("pe_en", pe_en_o, m_pe());
    chk("busy", busy_o, active);
    chk("done", done_o, m_done());
    chk("row_x", row_x_o, m_lanes(1'b1));
    chk("col_x", col_x_o, m_lanes(1'b0));
  endtask

  task automatic model_update();
    bit rdy, dn;
    rdy = m_ready();
    dn  = m_done();
    if (!active) begin
      if (start && (k_len != 8'd0)) begin
        active = 1'b1;
        t_clr  = cyc + 1;
        t_last = -1;
        k_rem  = k_len;
      end
    end else begin
      if (rdy && in_valid) begin
        ha[cyc] = a_vec;
        hb[cyc] = b_vec;
        k_rem--;
        if (k_rem == 0) t_last = cyc;
      end
      if (dn) active = 1'b0;
    end
    cyc++;
  endtask

  task automatic apply(input logic s, input logic [7:0] k, input logic v,
                       input logic [63:0] a, input logic [63:0] b);
    start = s; k_len = k; in_valid = v; a_vec = a; b_vec = b;
    #1;
    model_check();
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  typedef struct {
    logic       s;
    logic [7:0] k;
    logic       v;
    logic       rdy, clr, pe, busy, done;
    int         lane;
  } vec_t;

  vec_t        tbl [23];
  logic [63:0] pat_a, pat_b, er, ec;
  int          acc, lat;
  bit          found;

  initial begin
    for (int r = 0; r < 23; r++) begin
      tbl[r] = '{s:1'b0, k:8'd0, v:1'b0, rdy:1'b0, clr:1'b0, pe:1'b0,
                 busy:1'b0, done:1'b0, lane:-1};
    end
    tbl[0].s = 1'b1; tbl[0].k = 8'd1; tbl[0].v = 1'b1;
    tbl[1].v = 1'b1; tbl[1].clr = 1'b1; tbl[1].busy = 1'b1;
    tbl[2].v = 1'b1; tbl[2].rdy = 1'b1; tbl[2].pe = 1'b1; tbl[2].busy = 1'b1;
    for (int r = 3; r <= 20; r++) begin
      tbl[r].pe = 1'b1; tbl[r].busy = 1'b1; tbl[r].v = 1'b1;
      if (r <= 10) tbl[r].lane = r - 3;
    end
    tbl[21].s = 1'b1; tbl[21].k = 8'd3; tbl[21].busy = 1'b1; tbl[21].done = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pat_a[8*i +: 8] = 8'(8'h01 + i);
      pat_b[8*i +: 8] = 8'(8'h11 + i);
    end

    // Reset held with noisy inputs.
    rst = 1'b1; start = 1'b1; k_len = 8'd3; in_valid = 1'b1;
    a_vec = rnd64(); b_vec = rnd64();
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready_o, 0);
    chk("rst_row_x", row_x_o, 0);
    chk("rst_col_x", col_x_o, 0);
    chk("rst_pe_en", pe_en_o, 0);
    chk("rst_arr_clr", arr_clr_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    start = 1'b0; in_valid = 1'b0;
    rst = 1'b0;
    apply(0, 0, 0, '0, '0);
    tick();

    // K_LEN=1 skew and timing table.
    for (int r = 0; r < 23; r++) begin
      apply(tbl[r].s, tbl[r].k, tbl[r].v, pat_a, pat_b);
      er = '0;
      ec = '0;
      if (tbl[r].lane >= 0) begin
        er[8*tbl[r].lane +: 8] = 8'(8'h01 + tbl[r].lane);
        ec[8*tbl[r].lane +: 8] = 8'(8'h11 + tbl[r].lane);
      end
      chk("tbl_in_ready", in_ready_o, tbl[r].rdy);
      chk("tbl_arr_clr", arr_clr_o, tbl[r].clr);
      chk("tbl_pe_en", pe_en_o, tbl[r].pe);
      chk("tbl_busy", busy_o, tbl[r].busy);
      chk("tbl_done", done_o, tbl[r].done);
      chk("tbl_row_x", row_x_o, er);
      chk("tbl_col_x", col_x_o, ec);
      tick();
    end

    // START with K_LEN=0 must be ignored.
    apply(1, 0, 1, rnd64(), rnd64());
    tick();
    apply(0, 0, 0, '0, '0);
    chk("k0_busy", busy_o, 0);
    chk("k0_arr_clr", arr_clr_o, 0);
    tick();

    // Bubbles with K_LEN=4, START noise during FEED.
    apply(1, 4, 0, '0, '0);
    tick();
    apply(0, 0, 0, '0, '0);
    tick();
    acc = 0;
    for (int p = 0; p < 7; p++) begin
      apply((p % 2) == 1, 8'd9, (p % 2) == 0, rnd64(), rnd64());
      if (in_ready_o && in_valid) acc++;
      tick();
    end
    chk("bubble_accepts", acc, 4);
    found = 0;
    lat = 0;
    for (int n = 1; n <= 40 && !found; n++) begin
      apply(0, 0, 0, '0, '0);
      if (done_o) begin
        found = 1;
        lat = n;
      end
      tick();
    end
    chk("bubble_done_seen", found, 1);
    chk("bubble_done_lat", lat, DRAIN + 1);
    apply(0, 0, 0, '0, '0);
    tick();

    // Reset pulse while DRAIN count is 5, then a clean K_LEN=2 product.
    apply(1, 2, 0, '0, '0);
    tick();
    apply(0, 0, 0, '0, '0);
    tick();
    repeat (2) begin
      apply(0, 0, 1, rnd64(), rnd64());
      tick();
    end
    repeat (13) begin
      apply(0, 0, 0, '0, '0);
      tick();
    end
    apply(0, 0, 0, '0, '0);
    chk("pre_rst_pe_en", pe_en_o, 1);
    #1 rst = 1'b1;
    #1;
    chk("drain_rst_pe_en", pe_en_o, 0);
    chk("drain_rst_busy", busy_o, 0);
    chk("drain_rst_done", done_o, 0);
    chk("drain_rst_in_ready", in_ready_o, 0);
    chk("drain_rst_arr_clr", arr_clr_o, 0);
    chk("drain_rst_row_x", row_x_o, 0);
    chk("drain_rst_col_x", col_x_o, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    rst = 1'b0;
    repeat (3) begin
      apply(0, 0, 0, '0, '0);
      tick();
    end
    apply(1, 2, 0, '0, '0);
    tick();
    apply(0, 0, 0, '0, '0);
    tick();
    repeat (2) begin
      apply(0, 0, 1, rnd64(), rnd64());
      tick();
    end
    found = 0;
    for (int n = 1; n <= 40 && !found; n++) begin
      apply(0, 0, 0, '0, '0);
      if (done_o) found = 1;
      tick();
    end
    chk("post_rst_done_seen", found, 1);

    // Randomized traffic against the model.
    for (int n = 0; n < 900; n++) begin
      apply(($urandom % 6) == 0, 8'($urandom % 6), ($urandom % 3) != 0, rnd64(), rnd64());
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
